ex_mac_unit: RTL and testbench

//  Iterative 32x32 multiply / multiply-accumulate unit in the EX stage. Serves MULT, MULTU, MADD, MADDU, MSUB and MSUBU.

---
 rtl/ex_mac_unit_pkg.sv | 43 ++++
 rtl/ex_mac_unit_shift_add_core.sv | 61 ++++++
 rtl/ex_mac_unit.sv | 146 ++++++++++++++
 tb/tb_ex_mac_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mac_unit_pkg.sv
// Shared definitions for the EX-stage multiply / multiply-accumulate unit:
// operation codes, FSM state encoding, default operand width and small
// op-classification helpers used by the control logic.
package ex_mac_unit_pkg;

  localparam int MAC_WIDTH = 32;

  localparam logic [2:0] MAC_MULT  = 3'd0;
  localparam logic [2:0] MAC_MULTU = 3'd1;
  localparam logic [2:0] MAC_MADD  = 3'd2;
  localparam logic [2:0] MAC_MADDU = 3'd3;
  localparam logic [2:0] MAC_MSUB  = 3'd4;
  localparam logic [2:0] MAC_MSUBU = 3'd5;

  typedef enum logic [2:0] {
    MAC_IDLE = 3'd0,
    MAC_MUL  = 3'd1,
    MAC_FIX  = 3'd2,
    MAC_ACC  = 3'd3,
    MAC_DONE = 3'd4
  } mac_state_t;

  // True for any of the six codes this unit executes.
  function automatic logic mac_is_valid(input logic [2:0] op);
    return (op <= MAC_MSUBU);
  endfunction

  // Signed variants take absolute values and fix the sign after the multiply.
  function automatic logic mac_is_signed(input logic [2:0] op);
    return (op == MAC_MULT) || (op == MAC_MADD) || (op == MAC_MSUB);
  endfunction

  // Accumulating variants need the extra ACC step against the latched HI/LO.
  function automatic logic mac_is_acc(input logic [2:0] op);
    return (op >= MAC_MADD) && (op <= MAC_MSUBU);
  endfunction

  // Subtracting variants compute {hi,lo} - product.
  function automatic logic mac_is_sub(input logic [2:0] op);
    return (op == MAC_MSUB) || (op == MAC_MSUBU);
  endfunction

endpackage

// File: rtl/ex_mac_unit_shift_add_core.sv
// Datapath of the iterative multiplier: holds the unsigned operand
// magnitudes, the 2*WIDTH product/accumulator and the bit counter, and
// performs one radix-2 shift-add, a negate or an accumulate per command.
import ex_mac_unit_pkg::*;

module mac_shift_add_core #(
  parameter int WIDTH = MAC_WIDTH,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic               step,
  input  logic               negate,
  input  logic               accumulate,
  input  logic               acc_sub,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic [2*WIDTH-1:0] acc_base,
  output logic [2*WIDTH-1:0] prod,
  output logic [CW-1:0]      count
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] addend;

  // Multiplicand shifted to the weight of the multiplier bit under test.
  always_comb begin
    addend = {{WIDTH{1'b0}}, a} << count;
  end

  // Operand latch, shift-add step, sign fix and accumulate, one at a time.
  always_ff @(posedge clk) begin
    if (rst) begin
      a     <= '0;
      b     <= '0;
      prod  <= '0;
      count <= '0;
    end else if (init) begin
      a     <= a_in;
      b     <= b_in;
      prod  <= '0;
      count <= '0;
    end else if (step) begin
      if (b[count]) begin
        prod <= prod + addend;
      end
      if (count != LAST) begin
        count <= count + 1'b1;
      end
    end else if (negate) begin
      prod <= -prod;
    end else if (accumulate) begin
      prod <= acc_sub ? (acc_base - prod) : (acc_base + prod);
    end
  end

endmodule

// File: rtl/ex_mac_unit.sv
// EX-stage multiply / multiply-accumulate unit. Accepts a MAC-class
// instruction, stalls the front of the pipeline while the shift-add core
// iterates, and presents the HI/LO write for exactly one release cycle.
import ex_mac_unit_pkg::*;

module ex_mac_unit #(
  parameter int WIDTH = MAC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             annul,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic             stallreq,
  output logic             whilo,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mac_state_t state, state_next;

  logic [2:0]         op_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] hilo_q;

  logic               accept;
  logic               core_init;
  logic               core_step;
  logic               core_negate;
  logic               core_acc;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      count;

  // Operand magnitudes: signed ops multiply absolute values, unsigned pass through.
  always_comb begin
    abs_a = (mac_is_signed(op) && opa[WIDTH-1]) ? -opa : opa;
    abs_b = (mac_is_signed(op) && opb[WIDTH-1]) ? -opb : opb;
  end

  mac_shift_add_core #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .init       (core_init),
    .step       (core_step),
    .negate     (core_negate),
    .accumulate (core_acc),
    .acc_sub    (mac_is_sub(op_q)),
    .a_in       (abs_a),
    .b_in       (abs_b),
    .acc_base   (hilo_q),
    .prod       (prod),
    .count      (count)
  );

  // State register plus the per-instruction context captured on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MAC_IDLE;
      op_q   <= '0;
      neg_q  <= 1'b0;
      hilo_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q   <= op;
        neg_q  <= mac_is_signed(op) & (opa[WIDTH-1] ^ opb[WIDTH-1]);
        hilo_q <= {hi_i, lo_i};
      end
    end
  end

  // Next-state, datapath commands and pipeline-facing outputs; annul overrides all.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    core_init   = 1'b0;
    core_step   = 1'b0;
    core_negate = 1'b0;
    core_acc    = 1'b0;
    stallreq    = 1'b0;
    whilo       = 1'b0;
    hi_o        = '0;
    lo_o        = '0;
    case (state)
      MAC_IDLE: begin
        if (start && mac_is_valid(op)) begin
          accept     = 1'b1;
          core_init  = 1'b1;
          stallreq   = 1'b1;
          state_next = MAC_MUL;
        end
      end
      MAC_MUL: begin
        stallreq  = 1'b1;
        core_step = 1'b1;
        if (count == LAST) begin
          state_next = MAC_FIX;
        end
      end
      MAC_FIX: begin
        stallreq    = 1'b1;
        core_negate = neg_q;
        state_next  = mac_is_acc(op_q) ? MAC_ACC : MAC_DONE;
      end
      MAC_ACC: begin
        stallreq   = 1'b1;
        core_acc   = 1'b1;
        state_next = MAC_DONE;
      end
      MAC_DONE: begin
        whilo      = 1'b1;
        hi_o       = prod[2*WIDTH-1:WIDTH];
        lo_o       = prod[WIDTH-1:0];
        state_next = MAC_IDLE;
      end
      default: begin
        state_next = MAC_IDLE;
      end
    endcase
    if (annul) begin
      state_next  = MAC_IDLE;
      accept      = 1'b0;
      core_init   = 1'b0;
      core_step   = 1'b0;
      core_negate = 1'b0;
      core_acc    = 1'b0;
      stallreq    = 1'b0;
      whilo       = 1'b0;
      hi_o        = '0;
      lo_o        = '0;
    end
  end

endmodule

// File: tb/tb_ex_mac_unit.sv
// Scoreboard bench for ex_mac_unit: directed MAC vectors with hand-computed
// results are queued as they are issued; a negedge monitor pops and checks
// each whilo pulse (value and arrival cycle) and checks outputs idle at zero.
module tb_ex_mac_unit;
  import ex_mac_unit_pkg::*;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [2:0]  op    = '0;
  logic [31:0] opa   = '0;
  logic [31:0] opb   = '0;
  logic [31:0] hi_i  = '0;
  logic [31:0] lo_i  = '0;
  logic        stallreq;
  logic        whilo;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
    string       name;
  } exp_t;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] l;
    logic [63:0] result;
    int          lat;
    int          gap;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  ex_mac_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .annul    (annul),
    .op       (op),
    .opa      (opa),
    .opb      (opb),
    .hi_i     (hi_i),
    .lo_i     (lo_i),
    .stallreq (stallreq),
    .whilo    (whilo),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;

  // Free-running cycle index used to time-stamp expected results.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every whilo pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (whilo === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected whilo", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput({e.name, " hi"}, {32'd0, hi_o}, {32'd0, e.hi});
          checkOutput({e.name, " lo"}, {32'd0, lo_o}, {32'd0, e.lo});
          checkOutput({e.name, " cycle"}, 64'(cyc), 64'(e.due));
        end
      end else begin
        checkOutput("whilo idle", {63'd0, whilo}, 64'd0);
        checkOutput("hilo idle zero", {hi_o, lo_o}, 64'd0);
      end
    end
  end

  // Issue one instruction, hold start through its DONE cycle, check stallreq.
  task automatic applyStimulus(input vec_t v);
    int c0;
    op    = v.op;
    opa   = v.a;
    opb   = v.b;
    hi_i  = v.h;
    lo_i  = v.l;
    start = 1'b1;
    c0    = cyc;
    sb.push_back('{v.result[63:32], v.result[31:0], c0 + v.lat, v.name});
    for (int i = 0; i <= v.lat; i++) begin
      @(negedge clk);
      checkOutput({v.name, " stallreq"}, {63'd0, stallreq},
                  (i < v.lat) ? 64'd1 : 64'd0);
      next_cycle();
      if (i == 0) begin
        opa  = 32'hDEADBEEF;
        opb  = 32'h0BADF00D;
        hi_i = 32'hA5A5A5A5;
        lo_i = 32'h5A5A5A5A;
      end
    end
    start = 1'b0;
    repeat (v.gap) next_cycle();
  endtask

  initial begin
    vecs.push_back('{"multu_max",   MAC_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
                     64'hFFFFFFFE_00000001, 34, 1});
    vecs.push_back('{"mult_neg3x5", MAC_MULT,  32'hFFFFFFFD, 32'h00000005, 32'h0, 32'h0,
                     64'hFFFFFFFF_FFFFFFF1, 34, 1});
    vecs.push_back('{"madd_16m8",   MAC_MADD,  32'hFFFFFFFE, 32'h00000004, 32'h0, 32'h10,
                     64'h00000000_00000008, 35, 1});
    vecs.push_back('{"msubu_wrap",  MAC_MSUBU, 32'h00000001, 32'h00000001, 32'h0, 32'h0,
                     64'hFFFFFFFF_FFFFFFFF, 35, 0});
    vecs.push_back('{"maddu_wrap",  MAC_MADDU, 32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     64'h00000000_00000000, 35, 0});
    vecs.push_back('{"msub_100m21", MAC_MSUB,  32'hFFFFFFF9, 32'hFFFFFFFD, 32'h0, 32'h64,
                     64'h00000000_0000004F, 35, 2});
    vecs.push_back('{"mult_minsq",  MAC_MULT,  32'h80000000, 32'h80000000, 32'h0, 32'h0,
                     64'h40000000_00000000, 34, 0});
    vecs.push_back('{"mult_maxxm1", MAC_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
                     64'hFFFFFFFF_80000001, 34, 1});
    vecs.push_back('{"multu_shift", MAC_MULTU, 32'h12345678, 32'h00000010, 32'h0, 32'h0,
                     64'h00000001_23456780, 34, 1});
    vecs.push_back('{"multu_zero",  MAC_MULTU, 32'h00000000, 32'hFFFFFFFF, 32'h0, 32'h0,
                     64'h00000000_00000000, 34, 1});
    vecs.push_back('{"madd_carry",  MAC_MADD,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF,
                     64'h00000001_00000000, 35, 1});
    vecs.push_back('{"msub_negprod", MAC_MSUB, 32'h00000003, 32'hFFFFFFFC, 32'h0, 32'h0,
                     64'h00000000_0000000C, 35, 1});

    // Reset state while rst is held
    repeat (3) next_cycle();
    @(negedge clk);
    checkOutput("reset stallreq", {63'd0, stallreq}, 64'd0);
    checkOutput("reset whilo", {63'd0, whilo}, 64'd0);
    checkOutput("reset hilo", {hi_o, lo_o}, 64'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Non-MAC codes are ignored
    for (int c = 6; c <= 7; c++) begin
      op    = 3'(c);
      opa   = 32'd5;
      opb   = 32'd7;
      start = 1'b1;
      repeat (3) begin
        @(negedge clk);
        checkOutput("nonmac stallreq", {63'd0, stallreq}, 64'd0);
        next_cycle();
      end
    end
    start = 1'b0;
    next_cycle();

    // Directed MAC vectors, some issued back-to-back
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // annul has priority over start in IDLE
    op    = MAC_MULT;
    opa   = 32'd9;
    opb   = 32'd9;
    start = 1'b1;
    annul = 1'b1;
    @(negedge clk);
    checkOutput("annul_idle stallreq", {63'd0, stallreq}, 64'd0);
    next_cycle();
    start = 1'b0;
    annul = 1'b0;
    @(negedge clk);
    checkOutput("annul_idle stays idle", {63'd0, stallreq}, 64'd0);
    next_cycle();

    // MULT annulled at cycle 10, then MULTU 2x3 issued immediately
    op    = MAC_MULT;
    opa   = 32'hFFFFFFFD;
    opb   = 32'd5;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("annul_mid stallreq", {63'd0, stallreq}, 64'd1);
      next_cycle();
    end
    annul = 1'b1;
    @(negedge clk);
    checkOutput("annul_mid drop", {63'd0, stallreq}, 64'd0);
    next_cycle();
    annul = 1'b0;
    applyStimulus('{"after_annul", MAC_MULTU, 32'd2, 32'd3, 32'h0, 32'h0,
                    64'h00000000_00000006, 34, 1});

    // rst at cycle 20 of a MADD
    op    = MAC_MADD;
    opa   = 32'd7;
    opb   = 32'd7;
    hi_i  = 32'd1;
    lo_i  = 32'd1;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("rst_mid stallreq", {63'd0, stallreq}, 64'd1);
      next_cycle();
    end
    rst = 1'b1;
    next_cycle();
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid stallreq after", {63'd0, stallreq}, 64'd0);
    checkOutput("rst_mid whilo after", {63'd0, whilo}, 64'd0);
    checkOutput("rst_mid hilo after", {hi_o, lo_o}, 64'd0);
    next_cycle();
    @(negedge clk);
    checkOutput("rst_mid idle", {63'd0, stallreq}, 64'd0);
    next_cycle();

    // Final instruction after the reset to show the unit recovered
    applyStimulus('{"after_rst", MAC_MADDU, 32'd10, 32'd20, 32'h0, 32'd5,
                    64'h00000000_000000CD, 35, 3});

    checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
